// File: rtl/pipeline_elastic_fifo.sv
// First-word-fall-through elastic buffer with a registered head word.
// Sits behind the pipeline flop stage and absorbs downstream stalls so
// the upstream register stages can run freely. All outputs come straight
// from flops, so there is no combinational path from out_ready or in_valid
// to any output.
module pipeline_elastic_fifo #(
   parameter int DataWidth        = 64,
   parameter int Depth            = 4,
   parameter int AlmostFullThresh = 3,
   parameter int CountWidth       = $clog2(Depth) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DataWidth-1:0]  in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DataWidth-1:0]  out_data,
   output logic [CountWidth-1:0] count,
   output logic                  almost_full,
   output logic                  empty
);

   localparam int PtrW = $clog2(Depth);
   localparam logic [CountWidth-1:0] DepthC  = CountWidth'(Depth);
   localparam logic [CountWidth-1:0] ThreshC = CountWidth'(AlmostFullThresh);
   localparam logic [CountWidth-1:0] OneC    = CountWidth'(1);
   localparam logic [PtrW-1:0]       PtrOneC = PtrW'(1);

   // Storage array; never reset, only the pointers and count define validity.
   logic [DataWidth-1:0] mem_q [Depth];

   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]       rd_ptr_nxt;
   logic [CountWidth-1:0] count_q, count_d;
   logic [DataWidth-1:0]  head_q, head_d;
   logic                  out_valid_q, out_valid_d;
   logic                  in_ready_q, in_ready_d;
   logic                  almost_full_q, almost_full_d;
   logic                  empty_q, empty_d;

   logic push;
   logic pop;

   assign push       = in_valid & in_ready_q;
   assign pop        = out_valid_q & out_ready;
   assign rd_ptr_nxt = rd_ptr_q + PtrOneC;

   // Next-state computation: pointers, occupancy, head word and flags.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      head_d        = head_q;
      out_valid_d   = out_valid_q;
      in_ready_d    = in_ready_q;
      almost_full_d = almost_full_q;
      empty_d       = empty_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrOneC;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_nxt;
      end

      if (push && !pop) begin
         count_d = count_q + OneC;
      end else if (pop && !push) begin
         count_d = count_q - OneC;
      end

      // The head register mirrors the oldest entry. It only ever loads
      // in_data on an accepted push, so an X on in_data while in_valid is
      // low cannot reach out_data.
      if (pop && (count_q > OneC)) begin
         head_d = mem_q[rd_ptr_nxt];
      end else if (push && ((count_q == '0) || (pop && (count_q == OneC)))) begin
         head_d = in_data;
      end

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         head_d   = '0;
      end

      out_valid_d   = (count_d != '0);
      empty_d       = (count_d == '0);
      in_ready_d    = (count_d != DepthC);
      almost_full_d = (count_d >= ThreshC);
   end

   // Control and head registers; rst wins over flush and any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         head_q        <= '0;
         out_valid_q   <= 1'b0;
         in_ready_q    <= 1'b1;
         almost_full_q <= 1'b0;
         empty_q       <= 1'b1;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         head_q        <= head_d;
         out_valid_q   <= out_valid_d;
         in_ready_q    <= in_ready_d;
         almost_full_q <= almost_full_d;
         empty_q       <= empty_d;
      end
   end

   // Write accepted words into storage; a push in a reset/flush cycle is dropped.
   always_ff @(posedge clk) begin
      if (push && !rst && !flush) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = head_q;
   assign count       = count_q;
   assign almost_full = almost_full_q;
   assign empty       = empty_q;

endmodule

// File: tb/tb_pipeline_elastic_fifo.sv
// Bench for pipeline_elastic_fifo: directed vector table followed by
// streaming and random-backpressure sequences checked against a queue model.
module tb_pipeline_elastic_fifo;

   localparam int DW = 64;
   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] count;
   logic          almost_full;
   logic          empty;

   int tests;
   int fails;

   pipeline_elastic_fifo #(
      .DataWidth(DW),
      .Depth(4),
      .AlmostFullThresh(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .count(count),
      .almost_full(almost_full),
      .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          flush;
      logic          iv;
      logic [DW-1:0] id;
      logic          ordy;
      logic          ov;
      logic [DW-1:0] od;
      logic [CW-1:0] cnt;
      logic          irdy;
      logic          af;
      logic          emp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic f, logic iv, logic [DW-1:0] id,
                               logic ordy, logic ov, logic [DW-1:0] od,
                               logic [CW-1:0] cnt, logic irdy, logic af, logic emp);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
      v.ov = ov; v.od = od; v.cnt = cnt; v.irdy = irdy; v.af = af; v.emp = emp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] model_q[$];
   logic [DW-1:0] prev_od;
   logic          prev_stall;
   logic          do_push;
   logic          do_pop;
   int            pushed;
   int            popped;
   int            cyc;

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // Reset with a pending push, then idle with X data.
      vecs.push_back(mk(1,0,1,64'hAAAA,0, 0,0,0,1,0,1));
      vecs.push_back(mk(1,0,1,64'hAAAA,0, 0,0,0,1,0,1));
      for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,'x,0, 0,0,0,1,0,1));
      // Fill to full, a fifth word held off, then drain.
      vecs.push_back(mk(0,0,1,1,0, 1,1,1,1,0,0));
      vecs.push_back(mk(0,0,1,2,0, 1,1,2,1,0,0));
      vecs.push_back(mk(0,0,1,3,0, 1,1,3,1,1,0));
      vecs.push_back(mk(0,0,1,4,0, 1,1,4,0,1,0));
      vecs.push_back(mk(0,0,1,5,0, 1,1,4,0,1,0));
      vecs.push_back(mk(0,0,1,5,0, 1,1,4,0,1,0));
      vecs.push_back(mk(0,0,1,5,1, 1,2,3,1,1,0));
      vecs.push_back(mk(0,0,1,5,1, 1,3,3,1,1,0));
      vecs.push_back(mk(0,0,0,'x,1, 1,4,2,1,0,0));
      vecs.push_back(mk(0,0,0,'x,1, 1,5,1,1,0,0));
      vecs.push_back(mk(0,0,0,'x,1, 0,0,0,1,0,1));
      // Flush mid-operation with a push offered in the flush cycle.
      vecs.push_back(mk(0,0,1,7,0, 1,7,1,1,0,0));
      vecs.push_back(mk(0,0,1,8,0, 1,7,2,1,0,0));
      vecs.push_back(mk(0,0,1,9,0, 1,7,3,1,1,0));
      vecs.push_back(mk(0,1,1,10,0, 0,0,0,1,0,1));
      vecs.push_back(mk(0,0,1,11,0, 1,11,1,1,0,0));
      vecs.push_back(mk(0,0,0,'x,1, 0,0,0,1,0,1));
      // Simultaneous push and pop at count 1.
      vecs.push_back(mk(0,0,1,64'h55,0, 1,64'h55,1,1,0,0));
      vecs.push_back(mk(0,0,1,64'h66,1, 1,64'h66,1,1,0,0));
      vecs.push_back(mk(0,0,0,'x,1, 0,0,0,1,0,1));
      // Reset beats flush and push while full; nothing is left behind.
      vecs.push_back(mk(0,0,1,64'hA1,0, 1,64'hA1,1,1,0,0));
      vecs.push_back(mk(0,0,1,64'hA2,0, 1,64'hA1,2,1,0,0));
      vecs.push_back(mk(0,0,1,64'hA3,0, 1,64'hA1,3,1,1,0));
      vecs.push_back(mk(0,0,1,64'hA4,0, 1,64'hA1,4,0,1,0));
      vecs.push_back(mk(1,1,1,64'hBB,1, 0,0,0,1,0,1));
      vecs.push_back(mk(0,0,0,'x,1, 0,0,0,1,0,1));

      foreach (vecs[k]) begin
         rst = vecs[k].rst; flush = vecs[k].flush; in_valid = vecs[k].iv;
         in_data = vecs[k].id; out_ready = vecs[k].ordy;
         step();
         chk($sformatf("vec%0d out_valid", k), DW'(out_valid), DW'(vecs[k].ov));
         chk($sformatf("vec%0d count", k), DW'(count), DW'(vecs[k].cnt));
         chk($sformatf("vec%0d in_ready", k), DW'(in_ready), DW'(vecs[k].irdy));
         chk($sformatf("vec%0d almost_full", k), DW'(almost_full), DW'(vecs[k].af));
         chk($sformatf("vec%0d empty", k), DW'(empty), DW'(vecs[k].emp));
         if (vecs[k].ov || vecs[k].rst)
            chk($sformatf("vec%0d out_data", k), out_data, vecs[k].od);
      end
      rst = 1'b0; flush = 1'b0;

      // Streaming: one word per cycle, each visible one cycle after its push.
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         step();
         chk($sformatf("stream%0d out_valid", i), DW'(out_valid), DW'(1));
         chk($sformatf("stream%0d out_data", i), out_data, DW'(i));
         chk($sformatf("stream%0d count", i), DW'(count), DW'(1));
         chk($sformatf("stream%0d in_ready", i), DW'(in_ready), DW'(1));
      end
      in_valid = 1'b0;
      in_data  = 'x;
      step();
      chk("stream drain count", DW'(count), DW'(0));

      // Random backpressure against a queue scoreboard.
      pushed = 0; popped = 0; cyc = 0; prev_stall = 1'b0; prev_od = '0;
      while (popped < 10000 && cyc < 80000) begin
         chk("rnd count", DW'(count), DW'(model_q.size()));
         chk("rnd in_ready", DW'(in_ready), DW'(model_q.size() < 4));
         chk("rnd out_valid", DW'(out_valid), DW'(model_q.size() != 0));
         chk("rnd empty", DW'(empty), DW'(model_q.size() == 0));
         chk("rnd almost_full", DW'(almost_full), DW'(model_q.size() >= 3));
         if (model_q.size() != 0) chk("rnd out_data", out_data, model_q[0]);
         if (prev_stall) chk("rnd stall stable", out_data, prev_od);

         in_valid  = (pushed < 10000) && ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 1) == 1);
         in_data   = in_valid ? {32'(pushed), 32'($urandom)} : 'x;
         do_push   = in_valid && (model_q.size() < 4);
         do_pop    = out_ready && (model_q.size() != 0);
         prev_stall = (model_q.size() != 0) && !out_ready;
         prev_od    = out_data;
         step();
         cyc++;
         if (do_pop) begin
            void'(model_q.pop_front());
            popped++;
         end
         if (do_push) begin
            model_q.push_back(in_data);
            pushed++;
         end
      end
      tests++;
      if (popped < 10000) begin
         fails++;
         $display("FAIL rnd timeout: popped %0d, required 10000", popped);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
